// File: rtl/keyboard_scanner.sv
// keyboard_scanner
//
// Scanner for a 4x4 matrix keypad on the memory-mapped I/O bus. It synchronises
// and debounces the row lines, walks the columns to find a pressed key, and
// latches one 4-bit key code per press for software to read.
//
// Ports:
//   clock          system clock
//   reset          asynchronous, active-high reset
//   read_enable    I/O read strobe for this block
//   address[2:0]   register select: 000 key, 010 status, 100 raw
//   read_data_out  combinational read data (0 when not selected or unmapped)
//   row[3:0]       keypad rows, pulled up, active-low, asynchronous to clock
//   col[3:0]       column drive, active-low
//   irq            key-available interrupt (only with KEYBOARD_IRQ_EN defined)
//
// Optional feature: define KEYBOARD_IRQ_EN to add the irq output. Without it
// software polls status bit 0.
//
// Register map:
//   000  {12'b0, key_code}              read clears valid and overrun
//   010  {13'b0, busy, overrun, valid}  no side effects
//   100  {8'b0, col, row_s}             no side effects
//
// Scan FSM (advances only on the scan tick):
//   state       | meaning
//   ------------+----------------------------------------------------------
//   ST_IDLE     | all columns driven low, waiting for any row to drop
//   ST_SCAN     | driving one column at a time to find the pressed key
//   ST_DEBOUNCE | column held, counting ticks where the latched row stays low
//   ST_HELD     | code captured, waiting for all rows to go high
//   ST_RELEASE  | counting clean high ticks before returning to idle

module keyboard_scanner #(
  parameter logic [15:0] SCAN_DIV     = 16'd5000,
  parameter logic [3:0]  DEBOUNCE_CNT = 4'd4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        read_enable,
  input  logic [2:0]  address,
  output logic [15:0] read_data_out,
  input  logic [3:0]  row,
  output logic [3:0]  col
`ifdef KEYBOARD_IRQ_EN
  ,
  output logic        irq
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SCAN     = 3'd1,
    ST_DEBOUNCE = 3'd2,
    ST_HELD     = 3'd3,
    ST_RELEASE  = 3'd4
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [3:0]  row_meta;
  logic [3:0]  row_s;
  logic [15:0] tick_cnt;
  logic        tick;

  logic [1:0]  col_idx;
  logic [1:0]  row_idx;
  logic [3:0]  deb_cnt;
  logic [1:0]  row_first;
  logic        row_any;
  logic        cnt_done;

  logic        col_clear;
  logic        col_inc;
  logic        row_latch;
  logic        cnt_clear;
  logic        cnt_inc;
  logic        capture;

  logic        busy;
  logic [3:0]  key_code;
  logic        valid;
  logic        overrun;
  logic        read_key;

  // ---------------------------------------------------------------------------
  // Row synchroniser. Idle rows are pulled up, so reset to all-ones.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row_meta <= 4'hF;
      row_s    <= 4'hF;
    end else begin
      row_meta <= row;
      row_s    <= row_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Scan tick: down-counter, pulses at zero and reloads. Coming out of reset
  // the counter is zero, so the first cycle after reset is already a tick.
  // ---------------------------------------------------------------------------
  assign tick = (tick_cnt == 16'd0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tick_cnt <= 16'd0;
    end else if (tick) begin
      tick_cnt <= SCAN_DIV - 16'd1;
    end else begin
      tick_cnt <= tick_cnt - 16'd1;
    end
  end

  // Lowest-index row currently pulled low.
  always_comb begin
    row_first = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!row_s[i]) begin
        row_first = 2'(i);
      end
    end
  end

  assign row_any  = (row_s != 4'hF);
  // Compared before incrementing, so DEBOUNCE_CNT agreeing ticks are needed.
  assign cnt_done = (deb_cnt == (DEBOUNCE_CNT - 4'd1));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and datapath strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    col_clear  = 1'b0;
    col_inc    = 1'b0;
    row_latch  = 1'b0;
    cnt_clear  = 1'b0;
    cnt_inc    = 1'b0;
    capture    = 1'b0;
    if (tick) begin
      case (state)
        ST_IDLE: begin
          if (row_any) begin
            col_clear  = 1'b1;
            state_next = ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (row_any) begin
            row_latch  = 1'b1;
            cnt_clear  = 1'b1;
            state_next = ST_DEBOUNCE;
          end else if (col_idx == 2'd3) begin
            // Nothing found in any column: the idle wake-up was a glitch.
            state_next = ST_IDLE;
          end else begin
            col_inc = 1'b1;
          end
        end
        ST_DEBOUNCE: begin
          if (!row_s[row_idx]) begin
            if (cnt_done) begin
              capture    = 1'b1;
              state_next = ST_HELD;
            end else begin
              cnt_inc = 1'b1;
            end
          end else begin
            state_next = ST_IDLE;
          end
        end
        ST_HELD: begin
          if (!row_any) begin
            cnt_clear  = 1'b1;
            state_next = ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (!row_any) begin
            if (cnt_done) begin
              state_next = ST_IDLE;
            end else begin
              cnt_inc = 1'b1;
            end
          end else begin
            state_next = ST_HELD;
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. Outside idle the found column stays driven, so keys in other
  // columns cannot disturb the debounce or the release detection.
  // ---------------------------------------------------------------------------
  always_comb begin
    col  = ~(4'b0001 << col_idx);
    busy = 1'b1;
    if (state == ST_IDLE) begin
      col  = 4'b0000;
      busy = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Scan datapath: column index, latched row, debounce counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col_idx <= 2'd0;
      row_idx <= 2'd0;
      deb_cnt <= 4'd0;
    end else begin
      if (col_clear) begin
        col_idx <= 2'd0;
      end else if (col_inc) begin
        col_idx <= col_idx + 2'd1;
      end
      if (row_latch) begin
        row_idx <= row_first;
      end
      if (cnt_clear) begin
        deb_cnt <= 4'd0;
      end else if (cnt_inc) begin
        deb_cnt <= deb_cnt + 4'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Key register. A capture that coincides with a key read wins: the new code
  // stays valid and overrun keeps its old value.
  // ---------------------------------------------------------------------------
  assign read_key = read_enable && (address == 3'b000);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      key_code <= 4'd0;
      valid    <= 1'b0;
      overrun  <= 1'b0;
    end else if (capture) begin
      key_code <= {row_idx, col_idx};
      valid    <= 1'b1;
      if (!read_key) begin
        overrun <= overrun | valid;
      end
    end else if (read_key) begin
      valid   <= 1'b0;
      overrun <= 1'b0;
    end
  end

`ifdef KEYBOARD_IRQ_EN
  // Follows valid one cycle late, but drops on the edge that ends a key read.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      irq <= 1'b0;
    end else if (read_key && !capture) begin
      irq <= 1'b0;
    end else begin
      irq <= valid;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  always_comb begin
    read_data_out = 16'h0000;
    if (read_enable) begin
      case (address)
        3'b000:  read_data_out = {12'h000, key_code};
        3'b010:  read_data_out = {13'h0000, busy, overrun, valid};
        3'b100:  read_data_out = {8'h00, col, row_s};
        default: read_data_out = 16'h0000;
      endcase
    end
  end

endmodule

// File: tb/tb_keyboard_scanner.sv
// Testbench for keyboard_scanner (SCAN_DIV=4, DEBOUNCE_CNT=3).
// A keypad model turns the pressed-key set and the driven columns into row
// levels. A tick-level reference model predicts col and every readable
// register; one process compares the DUT against it on every falling edge.
// Directed press scenarios add hand-computed literal expectations.

module tb_keyboard_scanner;

  localparam int SD = 4;
  localparam int DB = 3;
  localparam int P_WAIT = 0, P_SEARCH = 1, P_CONFIRM = 2, P_HOLD = 3, P_LETGO = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        read_enable;
  logic [2:0]  address;
  logic [15:0] read_data_out;
  logic [3:0]  row;
  logic [3:0]  col;
`ifdef KEYBOARD_IRQ_EN
  logic        irq;
`endif

  logic [15:0] keys;   // bit r*4+c set = key at row r, column c pressed
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          cmp_on   = 1'b0;

  // reference model state
  int          m_phase, m_cyc, m_col_idx, m_row_idx, m_n;
  logic [3:0]  m_row_m, m_row_s, m_key;
  logic        m_valid, m_over, m_irq;

  keyboard_scanner #(.SCAN_DIV(16'd4), .DEBOUNCE_CNT(4'd3)) dut (
    .clock         (clock),
    .reset         (reset),
    .read_enable   (read_enable),
    .address       (address),
    .read_data_out (read_data_out),
    .row           (row),
    .col           (col)
`ifdef KEYBOARD_IRQ_EN
    ,
    .irq           (irq)
`endif
  );

  always #5 clock = ~clock;

  // Keypad: a row reads low if any pressed key in it sits on a driven column.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  function automatic int first_low(input logic [3:0] v);
    for (int i = 0; i < 4; i++)
      if (!v[i]) return i;
    return 0;
  endfunction

  function automatic logic [3:0] m_col();
    if (m_phase == P_WAIT) return 4'b0000;
    return ~(4'b0001 << m_col_idx);
  endfunction

  function automatic logic [15:0] exp_rdata();
    if (!read_enable) return 16'h0000;
    case (address)
      3'b000:  return {12'h000, m_key};
      3'b010:  return {13'h0000, (m_phase != P_WAIT), m_over, m_valid};
      3'b100:  return {8'h00, m_col(), m_row_s};
      default: return 16'h0000;
    endcase
  endfunction

  task automatic model_step();
    bit rd;
    bit cap;
    if (reset) begin
      m_phase = P_WAIT; m_cyc = 0; m_col_idx = 0; m_row_idx = 0; m_n = 0;
      m_row_m = 4'hF; m_row_s = 4'hF; m_key = 4'h0;
      m_valid = 1'b0; m_over = 1'b0; m_irq = 1'b0;
      return;
    end
    rd  = read_enable && (address == 3'b000);
    cap = 1'b0;
    if (m_cyc % SD == 0) begin
      case (m_phase)
        P_WAIT:
          if (m_row_s != 4'hF) begin m_col_idx = 0; m_phase = P_SEARCH; end
        P_SEARCH:
          if (m_row_s != 4'hF) begin
            m_row_idx = first_low(m_row_s); m_n = 0; m_phase = P_CONFIRM;
          end else if (m_col_idx == 3) m_phase = P_WAIT;
          else m_col_idx = m_col_idx + 1;
        P_CONFIRM:
          if (!m_row_s[m_row_idx]) begin
            if (m_n == DB - 1) begin cap = 1'b1; m_phase = P_HOLD; end
            else m_n = m_n + 1;
          end else m_phase = P_WAIT;
        P_HOLD:
          if (m_row_s == 4'hF) begin m_n = 0; m_phase = P_LETGO; end
        default:
          if (m_row_s == 4'hF) begin
            if (m_n == DB - 1) m_phase = P_WAIT;
            else m_n = m_n + 1;
          end else m_phase = P_HOLD;
      endcase
    end
    m_cyc = m_cyc + 1;
    m_irq = (rd && !cap) ? 1'b0 : m_valid;
    if (cap) begin
      m_key = 4'(m_row_idx * 4 + m_col_idx);
      if (!rd) m_over = m_over | m_valid;
      m_valid = 1'b1;
    end else if (rd) begin
      m_valid = 1'b0;
      m_over  = 1'b0;
    end
    m_row_s = m_row_m;
    m_row_m = row;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clock or posedge reset);
    model_step();
  end

  initial forever begin
    @(negedge clock);
    if (cmp_on) begin
      check("col", {12'h000, col}, {12'h000, m_col()});
      check("read_data_out", read_data_out, exp_rdata());
`ifdef KEYBOARD_IRQ_EN
      check("irq", {15'h0000, irq}, {15'h0000, m_irq});
`endif
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic wait_phase(input int p, input int max_cyc, input string what);
    int k;
    k = 0;
    while (m_phase != p && k < max_cyc) begin
      step();
      k++;
    end
    n_checks++;
    if (m_phase != p) begin
      n_fail++;
      $display("FAIL wait_%s: phase %0d expected %0d after %0d cycles", what, m_phase, p, k);
    end
  endtask

  task automatic check_status(input logic [15:0] exp, input string name);
    #1;
    check(name, read_data_out, exp);
  endtask

  task automatic read_key(input logic [15:0] exp, input string name);
    address = 3'b000;
    #1;
    check(name, read_data_out, exp);
    step();
    address = 3'b010;
  endtask

  initial begin
    int k;
    int mode;
    int a;
    reset = 1'b1;
    keys = 16'h0000;
    read_enable = 1'b1;
    address = 3'b010;
    repeat (2) @(posedge clock);
    #2;
    cmp_on = 1'b1;
    check("reset_col", {12'h000, col}, 16'h0000);
    check_status(16'h0000, "reset_status");
    address = 3'b100;
    #1;
    check("reset_raw", read_data_out, 16'h000F);
    address = 3'b010;
    step();
    reset = 1'b0;

    // row2/col1 held clean
    keys = 16'h1 << 9;
    wait_phase(P_HOLD, 200, "hold_9");
    check_status(16'h0005, "status_after_9");
    read_key(16'h0009, "key_9");
    check_status(16'h0004, "status_after_read_9");
    keys = 16'h0000;
    wait_phase(P_WAIT, 200, "idle_9");
    check_status(16'h0000, "status_idle_9");

    // row0/col3 with a bounce during debounce, then a clean re-press
    keys = 16'h1 << 3;
    wait_phase(P_CONFIRM, 200, "confirm_3");
    keys = 16'h0000;
    wait_phase(P_WAIT, 200, "bounce_3");
    check_status(16'h0000, "status_bounce_3");
    keys = 16'h1 << 3;
    wait_phase(P_HOLD, 200, "hold_3");
    check_status(16'h0005, "status_3");
    read_key(16'h0003, "key_3");
    keys = 16'h0000;
    wait_phase(P_WAIT, 200, "idle_3");

    // two presses without a read: overrun
    keys = 16'h1 << 5;
    wait_phase(P_HOLD, 200, "hold_5");
    keys = 16'h0000;
    wait_phase(P_WAIT, 200, "idle_5");
    keys = 16'h1 << 10;
    wait_phase(P_HOLD, 200, "hold_a");
    keys = 16'h0000;
    wait_phase(P_WAIT, 200, "idle_a");
    check_status(16'h0003, "status_overrun");
    read_key(16'h000A, "key_a");
    check_status(16'h0000, "status_overrun_cleared");

    // reset during debounce
    keys = 16'h1 << 6;
    wait_phase(P_CONFIRM, 200, "confirm_6");
    step();
    reset = 1'b1;
    #1;
    check("reset_mid_col", {12'h000, col}, 16'h0000);
    check_status(16'h0000, "reset_mid_status");
    repeat (3) step();
    reset = 1'b0;
    wait_phase(P_HOLD, 200, "hold_6");
    check_status(16'h0005, "status_6");
    read_key(16'h0006, "key_6");
    keys = 16'h0000;
    wait_phase(P_WAIT, 200, "idle_6");

    // long hold of 0xF, then a release with one bounce
    keys = 16'h1 << 15;
    wait_phase(P_HOLD, 200, "hold_f");
    repeat (50 * SD) step();
    check_status(16'h0005, "status_long_hold");
    read_key(16'h000F, "key_f");
    keys = 16'h0000;
    wait_phase(P_LETGO, 200, "letgo_f");
    keys = 16'h1 << 15;
    wait_phase(P_HOLD, 200, "rehold_f");
    check_status(16'h0004, "status_rehold");
    keys = 16'h0000;
    wait_phase(P_LETGO, 200, "letgo2_f");
    k = 0;
    while (m_phase != P_WAIT && k < 200) begin
      step();
      k++;
    end
    check("release_cycles", 16'(k), 16'(DB * SD));

    // unmapped address and deselected reads
    address = 3'b110;
    #1;
    check("unmapped_110", read_data_out, 16'h0000);
    read_enable = 1'b0;
    address = 3'b000;
    #1;
    check("deselected", read_data_out, 16'h0000);
    read_enable = 1'b1;
    address = 3'b010;

`ifdef KEYBOARD_IRQ_EN
    keys = 16'h0001;
    k = 0;
    while (!m_valid && k < 200) begin
      step();
      k++;
    end
    check("irq_valid_seen", {15'h0000, m_valid}, 16'h0001);
    check("irq_lags_valid", {15'h0000, irq}, 16'h0000);
    step();
    check("irq_rise", {15'h0000, irq}, 16'h0001);
    read_key(16'h0000, "key_0");
    check("irq_clear", {15'h0000, irq}, 16'h0000);
    keys = 16'h0000;
    wait_phase(P_WAIT, 200, "idle_0");
`endif

    // randomized keys and bus traffic
    for (int it = 0; it < 250; it++) begin
      mode = $urandom_range(0, 3);
      if (mode == 0) keys = 16'h0000;
      else if (mode < 3) keys = 16'h1 << $urandom_range(0, 15);
      else keys = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
      repeat ($urandom_range(1, 40)) begin
        a = $urandom_range(0, 15);
        read_enable = (a != 0);
        if (a < 2) address = 3'b000;
        else if (a < 8) address = 3'b010;
        else if (a < 12) address = 3'b100;
        else address = 3'($urandom_range(0, 7));
        step();
      end
    end
    keys = 16'h0000;
    read_enable = 1'b1;
    address = 3'b010;
    wait_phase(P_WAIT, 400, "final_idle");
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
